// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the RV32I multi-cycle control sequencer.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_BRJAL = 2'd1;
    localparam logic [1:0] PC_JALR  = 2'd2;

    typedef struct packed {
        logic op;
        logic op_imm;
        logic load;
        logic store;
        logic branch;
        logic lui;
        logic auipc;
        logic jal;
        logic jalr;
    } op_class_t;

    // Immediate format follows the instruction class; R-type falls back to I (unused).
    function automatic logic [2:0] imm_sel_of(input op_class_t c);
        if (c.store)                return IMM_S;
        else if (c.branch)          return IMM_B;
        else if (c.lui || c.auipc)  return IMM_U;
        else if (c.jal)             return IMM_J;
        return IMM_I;
    endfunction

endpackage

// File: rtl/rv_opcode_class.sv
// Combinational opcode classifier: one-hot class flags plus a legal indication.
module rv_opcode_class
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  cls,
    output logic       legal
);

    always_comb begin
        cls   = '0;
        legal = 1'b1;
        case (opcode)
            OPC_OP:     cls.op     = 1'b1;
            OPC_OP_IMM: cls.op_imm = 1'b1;
            OPC_LOAD:   cls.load   = 1'b1;
            OPC_STORE:  cls.store  = 1'b1;
            OPC_BRANCH: cls.branch = 1'b1;
            OPC_LUI:    cls.lui    = 1'b1;
            OPC_AUIPC:  cls.auipc  = 1'b1;
            OPC_JAL:    cls.jal    = 1'b1;
            OPC_JALR:   cls.jalr   = 1'b1;
            default:    legal      = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: state register, retired-instruction
// counter and per-state decode of memory handshakes and datapath selects.
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_valid,
    input  logic        imem_ready,
    output logic        ir_load,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    output logic        dmem_valid,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic [2:0]  imm_sel,
    output logic        alu_src_imm,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        illegal,
    output logic [31:0] instret,
    output logic [2:0]  state
);

    state_t      state_q;
    logic [31:0] instret_q;
    op_class_t   cls;
    logic        legal;

    rv_opcode_class u_class (
        .opcode (opcode),
        .cls    (cls),
        .legal  (legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (run) state_q <= S_FETCH;
                S_FETCH:  if (imem_ready) state_q <= S_DECODE;
                S_DECODE: state_q <= legal ? S_EXEC : S_HALT;
                S_EXEC: begin
                    if (cls.branch)                 state_q <= S_FETCH;
                    else if (cls.load || cls.store) state_q <= S_MEM;
                    else                            state_q <= S_WB;
                end
                S_MEM:    if (dmem_ready) state_q <= cls.load ? S_WB : S_FETCH;
                S_WB:     state_q <= S_FETCH;
                S_HALT:   state_q <= S_HALT;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    // Every PC update marks one retired instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (pc_we) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    always_comb begin
        imem_valid  = 1'b0;
        ir_load     = 1'b0;
        dmem_valid  = 1'b0;
        dmem_we     = 1'b0;
        imm_sel     = IMM_I;
        alu_src_imm = 1'b0;
        rf_we       = 1'b0;
        wb_sel      = WB_ALU;
        pc_we       = 1'b0;
        pc_sel      = PC_PLUS4;
        illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_valid = 1'b1;
                ir_load    = imem_ready;
            end
            S_DECODE: imm_sel = imm_sel_of(cls);
            S_EXEC: begin
                imm_sel     = imm_sel_of(cls);
                alu_src_imm = cls.op_imm | cls.load | cls.store | cls.jalr | cls.lui | cls.auipc;
                if (cls.branch) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_taken ? PC_BRJAL : PC_PLUS4;
                end
            end
            S_MEM: begin
                imm_sel    = imm_sel_of(cls);
                dmem_valid = 1'b1;
                dmem_we    = cls.store;
                pc_we      = cls.store & dmem_ready;
            end
            S_WB: begin
                imm_sel = imm_sel_of(cls);
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                if (cls.load)                wb_sel = WB_MEM;
                else if (cls.jal || cls.jalr) wb_sel = WB_PC4;
                if (cls.jal)       pc_sel = PC_BRJAL;
                else if (cls.jalr) pc_sel = PC_JALR;
            end
            S_HALT:  illegal = 1'b1;
            default: ;
        endcase
    end

    assign instret = instret_q;
    assign state   = state_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Scoreboard bench for rv_multicycle_ctrl: per-cycle expected outputs are queued
// from an instruction-level timing model and compared as the sequencer runs.
module tb_rv_multicycle_ctrl;

    localparam logic [6:0] T_OP_IMM = 7'h13;
    localparam logic [6:0] T_LOAD   = 7'h03;
    localparam logic [6:0] T_STORE  = 7'h23;
    localparam logic [6:0] T_BRANCH = 7'h63;
    localparam logic [6:0] T_LUI    = 7'h37;
    localparam logic [6:0] T_AUIPC  = 7'h17;
    localparam logic [6:0] T_JAL    = 7'h6F;
    localparam logic [6:0] T_JALR   = 7'h67;
    localparam logic [6:0] T_OP     = 7'h33;

    typedef struct packed {
        logic [2:0]  state;
        logic        imem_valid;
        logic        ir_load;
        logic        dmem_valid;
        logic        dmem_we;
        logic [2:0]  imm_sel;
        logic        alu_src_imm;
        logic        rf_we;
        logic [1:0]  wb_sel;
        logic        pc_we;
        logic [1:0]  pc_sel;
        logic        illegal;
        logic [31:0] instret;
    } obs_t;

    typedef struct packed {
        logic imem_ready;
        logic dmem_ready;
        logic branch_taken;
        obs_t exp;
    } step_t;

    logic        clk, rst_n, run;
    logic        imem_valid, imem_ready, ir_load;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        dmem_valid, dmem_we, dmem_ready;
    logic [2:0]  imm_sel;
    logic        alu_src_imm, rf_we;
    logic [1:0]  wb_sel;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        illegal;
    logic [31:0] instret;
    logic [2:0]  state;

    step_t       sb_q[$];
    logic [31:0] exp_instret;
    int          check_count = 0;
    int          pass_count  = 0;
    int          fail_count  = 0;

    rv_multicycle_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .imem_valid   (imem_valid),
        .imem_ready   (imem_ready),
        .ir_load      (ir_load),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .dmem_valid   (dmem_valid),
        .dmem_we      (dmem_we),
        .dmem_ready   (dmem_ready),
        .imm_sel      (imm_sel),
        .alu_src_imm  (alu_src_imm),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .illegal      (illegal),
        .instret      (instret),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got %0d checks, required completion", check_count);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input obs_t exp);
        obs_t got;
        got = '{state: state, imem_valid: imem_valid, ir_load: ir_load,
                dmem_valid: dmem_valid, dmem_we: dmem_we, imm_sel: imm_sel,
                alu_src_imm: alu_src_imm, rf_we: rf_we, wb_sel: wb_sel,
                pc_we: pc_we, pc_sel: pc_sel, illegal: illegal, instret: instret};
        check_count++;
        assert (got === exp) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h required %h (state %0d/%0d instret %h/%h)",
                   tag, got, exp, got.state, exp.state, got.instret, exp.instret);
        end
    endtask

    task automatic pushStep(input logic ir, input logic dr, input logic bt, input obs_t e);
        step_t s;
        s.imem_ready   = ir;
        s.dmem_ready   = dr;
        s.branch_taken = bt;
        s.exp          = e;
        sb_q.push_back(s);
    endtask

    // Timing model of one instruction starting at its FETCH entry cycle.
    task automatic queueInstr(input logic [6:0] op, input logic taken, input int iwait, input int dwait);
        obs_t       e;
        logic [2:0] imm_exp;
        logic       is_legal;
        is_legal = (op == T_OP) || (op == T_OP_IMM) || (op == T_LOAD) || (op == T_STORE) ||
                   (op == T_BRANCH) || (op == T_LUI) || (op == T_AUIPC) || (op == T_JAL) || (op == T_JALR);
        imm_exp = (op == T_STORE) ? 3'd1 : (op == T_BRANCH) ? 3'd2 :
                  (op == T_LUI || op == T_AUIPC) ? 3'd3 : (op == T_JAL) ? 3'd4 : 3'd0;
        for (int i = 0; i < iwait; i++) begin
            e = '0; e.state = 3'd1; e.imem_valid = 1'b1; e.instret = exp_instret;
            pushStep(1'b0, 1'b0, 1'b0, e);
        end
        e = '0; e.state = 3'd1; e.imem_valid = 1'b1; e.ir_load = 1'b1; e.instret = exp_instret;
        pushStep(1'b1, 1'b0, 1'b0, e);
        e = '0; e.state = 3'd2; e.imm_sel = imm_exp; e.instret = exp_instret;
        pushStep(1'b0, 1'b0, 1'b0, e);
        if (!is_legal) begin
            for (int i = 0; i < 20; i++) begin
                e = '0; e.state = 3'd6; e.illegal = 1'b1; e.instret = exp_instret;
                pushStep(1'b1, 1'b1, 1'b0, e);
            end
            return;
        end
        e = '0; e.state = 3'd3; e.imm_sel = imm_exp; e.instret = exp_instret;
        e.alu_src_imm = (op == T_OP_IMM) || (op == T_LOAD) || (op == T_STORE) ||
                        (op == T_JALR) || (op == T_LUI) || (op == T_AUIPC);
        if (op == T_BRANCH) begin
            e.pc_we  = 1'b1;
            e.pc_sel = taken ? 2'd1 : 2'd0;
            pushStep(1'b0, 1'b0, taken, e);
            exp_instret++;
            return;
        end
        pushStep(1'b0, 1'b0, taken, e);
        if (op == T_LOAD || op == T_STORE) begin
            for (int i = 0; i < dwait; i++) begin
                e = '0; e.state = 3'd4; e.dmem_valid = 1'b1; e.dmem_we = (op == T_STORE);
                e.imm_sel = imm_exp; e.instret = exp_instret;
                pushStep(1'b0, 1'b0, 1'b0, e);
            end
            e = '0; e.state = 3'd4; e.dmem_valid = 1'b1; e.dmem_we = (op == T_STORE);
            e.imm_sel = imm_exp; e.instret = exp_instret; e.pc_we = (op == T_STORE);
            pushStep(1'b0, 1'b1, 1'b0, e);
            if (op == T_STORE) begin
                exp_instret++;
                return;
            end
        end
        e = '0; e.state = 3'd5; e.imm_sel = imm_exp; e.rf_we = 1'b1; e.pc_we = 1'b1;
        e.instret = exp_instret;
        e.wb_sel = (op == T_LOAD) ? 2'd1 : (op == T_JAL || op == T_JALR) ? 2'd2 : 2'd0;
        e.pc_sel = (op == T_JAL) ? 2'd1 : (op == T_JALR) ? 2'd2 : 2'd0;
        pushStep(1'b0, 1'b0, 1'b0, e);
        exp_instret++;
    endtask

    // Pops up to n steps (all when n < 0): drive after the falling edge, compare 1ns later.
    task automatic applyStimulus(input string tag, input int n);
        step_t s;
        int    done = 0;
        while (sb_q.size() > 0 && (n < 0 || done < n)) begin
            s = sb_q.pop_front();
            imem_ready   = s.imem_ready;
            dmem_ready   = s.dmem_ready;
            branch_taken = s.branch_taken;
            #1;
            checkOutput($sformatf("%s[%0d]", tag, done), s.exp);
            done++;
            @(negedge clk);
        end
        imem_ready   = 1'b0;
        dmem_ready   = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic startRun();
        run = 1'b1;
        #1;
        checkOutput("idle_run", '0);
        @(negedge clk);
        run = 1'b0;
    endtask

    initial begin
        obs_t zero_obs;
        zero_obs     = '0;
        rst_n        = 1'b0;
        run          = 1'b0;
        imem_ready   = 1'b0;
        dmem_ready   = 1'b0;
        branch_taken = 1'b0;
        opcode       = T_OP_IMM;
        exp_instret  = '0;
        repeat (2) @(negedge clk);
        checkOutput("in_reset", zero_obs);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle", zero_obs);
        startRun();

        opcode = T_OP_IMM; queueInstr(T_OP_IMM, 1'b0, 0, 0); applyStimulus("addi", -1);
        opcode = T_LOAD;   queueInstr(T_LOAD,   1'b0, 0, 2); applyStimulus("lw_wait2", -1);
        opcode = T_BRANCH; queueInstr(T_BRANCH, 1'b1, 0, 0); applyStimulus("beq_taken", -1);
        opcode = T_BRANCH; queueInstr(T_BRANCH, 1'b0, 0, 0); applyStimulus("beq_not", -1);
        opcode = T_JALR;   queueInstr(T_JALR,   1'b0, 0, 0); applyStimulus("jalr", -1);
        opcode = T_STORE;  queueInstr(T_STORE,  1'b0, 0, 0); applyStimulus("sw", -1);
        opcode = T_JAL;    queueInstr(T_JAL,    1'b0, 1, 0); applyStimulus("jal_iwait", -1);
        opcode = T_LUI;    queueInstr(T_LUI,    1'b0, 0, 0); applyStimulus("lui", -1);
        opcode = T_OP;     queueInstr(T_OP,     1'b0, 2, 0); applyStimulus("add_iwait2", -1);
        opcode = T_AUIPC;  queueInstr(T_AUIPC,  1'b0, 0, 0); applyStimulus("auipc", -1);

        // Counter wrap: preload all-ones during a FETCH cycle, then retire one instruction.
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        exp_instret = 32'hFFFF_FFFF;
        opcode = T_OP_IMM; queueInstr(T_OP_IMM, 1'b0, 0, 0); applyStimulus("wrap", -1);
        assert (exp_instret === 32'd0) else $display("[TB] model counter did not wrap");

        // Asynchronous reset while a store is waiting in MEM.
        opcode = T_STORE;
        queueInstr(T_STORE, 1'b0, 0, 3);
        applyStimulus("sw_reset", 4);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_mem", zero_obs);
        sb_q.delete();
        exp_instret = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_after_reset", zero_obs);
        startRun();

        opcode = T_OP_IMM; queueInstr(T_OP_IMM, 1'b0, 0, 0); applyStimulus("addi2", -1);
        opcode = 7'h7F;    queueInstr(7'h7F,    1'b0, 0, 0); applyStimulus("illegal", -1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
